mnist_binarize_pack: RTL
========================

MNIST_BINARIZE_PACK -- requirements
Module: mnist_binarize_pack

Interface
REQ-001 Parameter N_PIX, default 784, number of pixels per frame (28x28, row-major).
REQ-002 Parameter PIX_W, default 8, pixel width in bits (unsigned grayscale).
REQ-003 Parameter CNT_W, default 10, frame pixel-counter width; SHALL satisfy 2^CNT_W > N_PIX.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all flops rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 i_valid  in  1  pixel present on i_pixel.
REQ-008 i_pixel  in  PIX_W  unsigned grayscale pixel.
REQ-009 i_last  in  1  marks final pixel of a frame; qualified by i_valid.
REQ-010 i_bin_thr  in  PIX_W  binarization threshold; sampled on first accepted pixel of each frame.
REQ-011 o_ready  out  1  block can accept a pixel this cycle.
REQ-012 o_data  out  N_PIX  packed binary frame; feeds the BNN top i_data.
REQ-013 o_valid  out  1  one-cycle pulse; o_data holds a complete frame.
REQ-014 o_err  out  1  one-cycle pulse; framing error detected.

Function
REQ-015 A pixel SHALL be accepted on a rising edge where i_valid && o_ready.
REQ-016 FSM states SHALL be S_IDLE, S_FILL and S_EMIT.
REQ-017 S_IDLE: o_ready=1; on accept, latch i_bin_thr, write bit 0, cnt<=1, go to S_FILL. If i_last is also set, take REQ-021 instead.
REQ-018 S_FILL: o_ready=1; each accept writes the bit at index cnt, cnt<=cnt+1; no accept leaves all state unchanged (gaps are allowed).
REQ-019 Bit for pixel n SHALL be 1 iff i_pixel > latched threshold (strict, unsigned). It SHALL be stored at o_data[N_PIX-1-n], so pixel 0 is the MSB.
REQ-020 Accept of pixel n=N_PIX-1 SHALL go to S_EMIT, whether or not i_last is set.
REQ-021 i_last on an accept with n<N_PIX-1 SHALL:
  - discard the partial frame;
  - pulse o_err the next cycle;
  - leave o_data unchanged and suppress o_valid;
  - set cnt<=0 and go to S_IDLE.
REQ-022 Accept of pixel N_PIX-1 without i_last SHALL still emit the frame, and SHALL pulse o_err in the same cycle as o_valid.
REQ-023 S_EMIT: o_ready=0 and o_valid=1 for exactly one cycle, with o_data equal to the completed frame; next state S_IDLE, cnt<=0.
REQ-024 Latency: o_valid SHALL assert on the cycle after the edge that accepts pixel N_PIX-1. Throughput: one frame per N_PIX+1 cycles minimum (one bubble per frame).
REQ-025 The packing register SHALL be separate from the o_data output register. o_data SHALL update only on the S_FILL-to-S_EMIT transition and otherwise hold its last emitted frame.
REQ-026 Pixel bits not yet written in the current frame SHALL never appear on o_data.
REQ-027 i_pixel, i_last and i_bin_thr SHALL be ignored when i_valid=0 or o_ready=0.
REQ-028 The counter SHALL never exceed N_PIX-1 and SHALL not wrap.

Reset
REQ-029 On rst_n low, all of the following SHALL clear immediately, regardless of clk:
  - state=S_IDLE, cnt=0, threshold=0;
  - packing register=0;
  - o_data=0, o_valid=0, o_err=0.
REQ-030 While in reset and after release, o_ready SHALL be 1.
REQ-031 Reset mid-frame SHALL discard the partial frame with no o_valid or o_err pulse. The next accepted pixel SHALL be pixel 0.

Structure
REQ-032 N_PIX, PIX_W and the FSM state encoding SHALL live in shared package bnn_pkg, used by the BNN top and this block.
REQ-033 No sub-module: a single module of FSM, counter, packing register and output register.

Verification
REQ-034 Reset, then 784 pixels back-to-back with value 200, threshold 127, i_last on pixel 783 -> o_valid one cycle later, o_data=all ones, o_err=0.
REQ-035 Pixel n=n mod 256, threshold 127 -> o_data[783-n]=1 exactly where (n mod 256)>127. Pixels equal to 127 SHALL give 0.
REQ-036 i_last on pixel 500 -> o_err pulse, no o_valid, o_data keeps the previous frame. The next full frame emits correctly.
REQ-037 784 pixels without i_last -> o_valid and o_err pulse together, frame emitted.
REQ-038 Random i_valid gaps (50% duty) across two back-to-back frames -> both frames correct, and o_ready=0 for exactly one cycle after each final accept.
REQ-039 rst_n asserted asynchronously at pixel 300 -> outputs clear immediately. The subsequent full 784-pixel frame of value 0 -> o_data=0, o_valid pulse, no o_err.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared frame geometry and binarizer FSM encoding for the BNN datapath.
package bnn_pkg;
  localparam int N_PIX = 784;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT} state_t;
endpackage

// File: rtl/mnist_binarize_pack.sv
// mnist_binarize_pack: thresholds a pixel stream and packs each frame MSB-first into one wide word.
module mnist_binarize_pack
  import bnn_pkg::*;
#(
  parameter int N_PIX = bnn_pkg::N_PIX,
  parameter int PIX_W = bnn_pkg::PIX_W,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_pixel,
  input  logic             i_last,
  input  logic [PIX_W-1:0] i_bin_thr,
  output logic             o_ready,
  output logic [N_PIX-1:0] o_data,
  output logic             o_valid,
  output logic             o_err
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PIX - 1);
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PIX_W-1:0]   thr;
  logic [N_PIX-1:0]   pack, pack_nx;
  logic               acc, bit_v, at_end;
  assign o_ready = state != S_EMIT;
  assign acc     = i_valid && o_ready;
  // pixel 0 is compared against the threshold arriving with it, later pixels against the latched one
  assign bit_v   = i_pixel > (state == S_IDLE ? i_bin_thr : thr);
  assign at_end  = state == S_FILL && cnt == LAST;
  always_comb begin
    pack_nx = pack;
    pack_nx[LAST - cnt] = bit_v;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      thr     <= '0;
      pack    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (state == S_EMIT) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (acc) begin
        if (state == S_IDLE) thr <= i_bin_thr;
        if (at_end) begin
          o_data  <= pack_nx;
          o_valid <= 1'b1;
          o_err   <= !i_last;
          state   <= S_EMIT;
        end else if (i_last) begin
          o_err <= 1'b1;
          cnt   <= '0;
          state <= S_IDLE;
        end else begin
          pack  <= pack_nx;
          cnt   <= cnt + 1'b1;
          state <= S_FILL;
        end
      end
    end
  end
endmodule
